riscv_dmem_arbiter: RTL and testbench
=====================================

// Module: riscv_dmem_arbiter
// PURPOSE
//  Shares the single-port 256x16 data memory between two requesters: port 0 is the
//  pipeline MEM stage (lw/sw) and port 1 is the debug/program-loader port.
//  Round-robin arbitration with a request/grant/read-valid handshake.
//  The block absorbs memory read latency and returns one response per granted read.
//  It sits between the MEM stage and the data memory macro.
// PARAMETERS
//  ADDR_W    8   word-address width; memory depth is 2**ADDR_W
//  DATA_W    16  data width
//  READ_LAT  1   cycles from mem_en (read) to valid mem_rdata; legal range 1..7
// PORTS
//  clock      in   1       system clock, rising edge
//  reset      in   1       synchronous, active-high
//  m0_req     in   1       port 0 request; held until m0_gnt
//  m0_we      in   1       1 = write, 0 = read
//  m0_addr    in   ADDR_W  word address
//  m0_wdata   in   DATA_W  write data
//  m0_gnt     out  1       one-cycle pulse; request accepted and issued
//  m0_rvalid  out  1       one-cycle pulse; m0_rdata valid
//  m0_rdata   out  DATA_W  read data; holds its value until the next m0_rvalid
//  m1_*       -    -       identical set for port 1
//  mem_en     out  1       memory access strobe
//  mem_we     out  1       memory write enable; qualified by mem_en
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data; valid READ_LAT cycles after a read mem_en
//  busy       out  1       state != IDLE; the MEM stage stalls on m0_req & ~m0_gnt
// BEHAVIOUR
//  - Reset (synchronous): state=IDLE, all gnt/rvalid/mem_en/mem_we=0, rdata regs=0,
//    mem_addr/mem_wdata=0, rr_last=1 (port 0 has priority first).
//  - FSM states: IDLE, ACCESS, WAIT, RESP.
//  - IDLE: if neither port requests, stay. If exactly one requests, pick it. If both
//    request, pick the port != rr_last. Latch winner id, we, addr and wdata.
//    Set rr_last=winner. Go to ACCESS.
//  - ACCESS (1 cycle): mem_en=1, mem_we=latched we, mem_addr/wdata=latched values,
//    gnt[winner]=1. Write: go to IDLE. Read: go to WAIT, cnt=READ_LAT-1.
//  - WAIT: spans READ_LAT cycles. In its last cycle (cnt==0), register mem_rdata
//    into rdata[winner]. Otherwise decrement cnt. Then go to RESP.
//  - RESP (1 cycle): rvalid[winner]=1. Go to IDLE.
//  - Latency, request seen at cycle N: gnt at N+1; write returns to IDLE at N+2.
//    For a read, rvalid is at N+2+READ_LAT; with READ_LAT=1 that is N+3.
//  - Requests are sampled only in IDLE. Req during ACCESS/WAIT/RESP is ignored, not lost.
//  - A requester drops req in the cycle after gnt. Req still high in IDLE is a new request.
//  - Only one transaction is in flight. No pipelining.
//  - mem_en is never asserted outside ACCESS.
//  - Payload is latched in IDLE. Changes to m*_addr/wdata after that have no effect.
//  - rvalid goes only to the granted port. The other port's rdata is unchanged.
//  - Fairness: with both ports requesting continuously, grants alternate 0,1,0,1...
//    No port waits more than one foreign transaction.
//  - Reset in any state aborts: no gnt, rvalid or mem_en in the following cycle.
//    Memory contents written before reset are preserved.
//  - Address width: no range check; addresses wrap modulo 2**ADDR_W by construction.
// STRUCTURE
//  - Shared package riscv_pkg: ADDR_W/DATA_W defaults and the arb_state_t
//    encoding (IDLE=0, ACCESS=1, WAIT=2, RESP=3).
//  - Sub-module rr_arb2: inputs req[1:0] and last. Outputs gnt_onehot[1:0] and
//    any. Purely combinational.
//  - Top: FSM, latency counter, payload latch and rdata registers.
// TESTING
//  1. m0 write addr=0 data=15 at N -> m0_gnt@N+1, mem_en&mem_we@N+1 with addr 0,
//     data 15; then m0 read addr=0 -> m0_rvalid@N'+3, m0_rdata=15.
//  2. m0,m1 both read at the same cycle after reset -> m0 granted first; m1
//     granted in the cycle after m0_rvalid's RESP. Each gets its own data.
//  3. Both ports requesting continuously for 6 transactions -> grant order
//     0,1,0,1,0,1. The non-granted rvalid stays 0 throughout.
//  4. READ_LAT=3, m1 reads addr=0xFF holding 0xBEEF -> mem_en@N+1, m1_rvalid@N+5,
//     m1_rdata=0xBEEF, busy high N+1..N+5.
//  5. Reset asserted during WAIT -> next cycle IDLE, busy=0, no rvalid, no mem_en.
//     m0 read afterwards completes normally.
//  6. m0_req held high across gnt (protocol misuse) -> treated as a second request.
//     With m1 requesting at the same time, m1 is served before m0's repeat.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory arbiter: default widths and FSM encoding.
package riscv_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  // Width of the read-latency down-counter; READ_LAT is limited to 1..7.
  localparam int LAT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // One-hot port vector for a single-bit port id.
  function automatic logic [1:0] port_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port
// that was not served last wins. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt_onehot,
  output logic       any
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      localparam logic SELF = (gi == 1);
      // Win when alone, or when both ask and the other port was served last.
      assign gnt_onehot[gi] = req[gi] & (~req[1-gi] | (last != SELF));
    end
  endgenerate

  assign any = |req;

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (port 0) and the
// debug/loader port (port 1). One transaction in flight; round-robin on ties.
module riscv_dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t             state_reg;
  logic                   winner_reg;
  logic                   we_reg;
  logic                   rr_last_reg;
  logic [LAT_CNT_W-1:0]   cnt_reg;
  logic [1:0]             gnt_reg;
  logic [1:0]             rvalid_reg;
  logic [1:0][DATA_W-1:0] rdata_reg;
  logic                   mem_en_reg;
  logic                   mem_we_reg;
  logic [ADDR_W-1:0]      mem_addr_reg;
  logic [DATA_W-1:0]      mem_wdata_reg;

  logic [1:0]             req_vec;
  logic [1:0]             arb_gnt;
  logic                   arb_any;
  logic                   pick_next;
  logic                   pick_we_next;
  logic [ADDR_W-1:0]      pick_addr_next;
  logic [DATA_W-1:0]      pick_wdata_next;

  assign req_vec = {m1_req, m0_req};

  rr_arb2 u_rr_arb2 (
    .req        (req_vec),
    .last       (rr_last_reg),
    .gnt_onehot (arb_gnt),
    .any        (arb_any)
  );

  // Payload of whichever port the arbiter picks this cycle.
  assign pick_next       = arb_gnt[1];
  assign pick_we_next    = pick_next ? m1_we    : m0_we;
  assign pick_addr_next  = pick_next ? m1_addr  : m0_addr;
  assign pick_wdata_next = pick_next ? m1_wdata : m0_wdata;

  // Arbitration FSM: latch the winner in IDLE, issue in ACCESS, wait out
  // the memory latency, then pulse rvalid to the winner only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      winner_reg    <= 1'b0;
      we_reg        <= 1'b0;
      rr_last_reg   <= 1'b1;
      cnt_reg       <= '0;
      gnt_reg       <= '0;
      rvalid_reg    <= '0;
      rdata_reg     <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      gnt_reg    <= '0;
      rvalid_reg <= '0;
      mem_en_reg <= 1'b0;
      mem_we_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            winner_reg    <= pick_next;
            we_reg        <= pick_we_next;
            rr_last_reg   <= pick_next;
            mem_addr_reg  <= pick_addr_next;
            mem_wdata_reg <= pick_wdata_next;
            gnt_reg       <= arb_gnt;
            mem_en_reg    <= 1'b1;
            mem_we_reg    <= pick_we_next;
            state_reg     <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_reg) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg   <= LAT_CNT_W'(READ_LAT - 1);
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            rdata_reg[winner_reg] <= mem_rdata;
            rvalid_reg            <= port_onehot(winner_reg);
            state_reg             <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign m0_gnt    = gnt_reg[0];
  assign m1_gnt    = gnt_reg[1];
  assign m0_rvalid = rvalid_reg[0];
  assign m1_rvalid = rvalid_reg[1];
  assign m0_rdata  = rdata_reg[0];
  assign m1_rdata  = rdata_reg[1];
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Randomised bench for riscv_dmem_arbiter: two instances (READ_LAT 1 and 3),
// each with its own memory model, checked cycle by cycle against a
// transaction-level schedule computed from the arbitration rules.
module tb_riscv_dmem_arbiter;

  localparam int NI   = 2;
  localparam int MAXC = 128;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
  } txn_t;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic mem_init = 1'b1;
  always #5 clock = ~clock;

  logic        m0_req_s [NI], m0_we_s [NI], m0_gnt_s [NI], m0_rvalid_s [NI];
  logic [7:0]  m0_addr_s [NI];
  logic [15:0] m0_wdata_s [NI], m0_rdata_s [NI];
  logic        m1_req_s [NI], m1_we_s [NI], m1_gnt_s [NI], m1_rvalid_s [NI];
  logic [7:0]  m1_addr_s [NI];
  logic [15:0] m1_wdata_s [NI], m1_rdata_s [NI];
  logic        mem_en_s [NI], mem_we_s [NI], busy_s [NI];
  logic [7:0]  mem_addr_s [NI];
  logic [15:0] mem_wdata_s [NI], mem_rdata_s [NI];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [15:0] init_word(input int d, input int a);
    return 16'((a * 257) ^ ((d == 0) ? 32'h1234 : 32'h5A5A));
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 1 : 3;
      logic [15:0] mem_arr [256];
      logic [15:0] pipe [8];

      riscv_dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .READ_LAT(LAT)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .m0_req    (m0_req_s[gi]),
        .m0_we     (m0_we_s[gi]),
        .m0_addr   (m0_addr_s[gi]),
        .m0_wdata  (m0_wdata_s[gi]),
        .m0_gnt    (m0_gnt_s[gi]),
        .m0_rvalid (m0_rvalid_s[gi]),
        .m0_rdata  (m0_rdata_s[gi]),
        .m1_req    (m1_req_s[gi]),
        .m1_we     (m1_we_s[gi]),
        .m1_addr   (m1_addr_s[gi]),
        .m1_wdata  (m1_wdata_s[gi]),
        .m1_gnt    (m1_gnt_s[gi]),
        .m1_rvalid (m1_rvalid_s[gi]),
        .m1_rdata  (m1_rdata_s[gi]),
        .mem_en    (mem_en_s[gi]),
        .mem_we    (mem_we_s[gi]),
        .mem_addr  (mem_addr_s[gi]),
        .mem_wdata (mem_wdata_s[gi]),
        .mem_rdata (mem_rdata_s[gi]),
        .busy      (busy_s[gi])
      );

      // Memory macro model: write on strobe, read data LAT cycles after the access.
      always @(posedge clock) begin
        if (mem_init) begin
          for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(gi, i);
        end else if (mem_en_s[gi] && mem_we_s[gi]) begin
          mem_arr[mem_addr_s[gi]] <= mem_wdata_s[gi];
        end
        pipe[0] <= mem_arr[mem_addr_s[gi]];
        for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_rdata_s[gi] = pipe[LAT-1];
    end
  endgenerate

  // Reference state
  logic [15:0] ref_mem [NI][256];
  logic        rr_last [NI];
  logic [15:0] exp_rd [NI][2];
  txn_t        pq [2][$];
  int          start_av [2];

  // Per-cycle schedule of the current burst
  logic [1:0]  exp_gnt [MAXC];
  logic [1:0]  exp_rv [MAXC];
  logic        exp_en [MAXC];
  logic        exp_we [MAXC];
  logic        exp_busy [MAXC];
  logic [7:0]  exp_addr [MAXC];
  logic [15:0] exp_wdata [MAXC];
  logic [15:0] rv_data [MAXC];
  logic [15:0] exp_rdv [MAXC][2];
  logic        drv_req [MAXC][2];
  logic        drv_junk [MAXC][2];
  txn_t        drv_txn [MAXC][2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [7:0] a, input logic [15:0] dt);
    txn_t t;
    t.we = we; t.addr = a; t.data = dt;
    return t;
  endfunction

  task automatic drive_port(input int d, input int p, input logic req, input logic we,
                            input logic [7:0] addr, input logic [15:0] data);
    if (p == 0) begin
      m0_req_s[d] = req; m0_we_s[d] = we; m0_addr_s[d] = addr; m0_wdata_s[d] = data;
    end else begin
      m1_req_s[d] = req; m1_we_s[d] = we; m1_addr_s[d] = addr; m1_wdata_s[d] = data;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < NI; d++) begin
      rr_last[d]   = 1'b1;
      exp_rd[d][0] = 16'h0;
      exp_rd[d][1] = 16'h0;
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    string s;
    s = $sformatf("i%0d %s", d, tag);
    check_val({s, " gnt"},    {m1_gnt_s[d], m0_gnt_s[d]}, 2'b00);
    check_val({s, " rvalid"}, {m1_rvalid_s[d], m0_rvalid_s[d]}, 2'b00);
    check_val({s, " mem_en"}, mem_en_s[d], 1'b0);
    check_val({s, " mem_we"}, mem_we_s[d], 1'b0);
    check_val({s, " mem_addr"}, mem_addr_s[d], 8'h00);
    check_val({s, " mem_wdata"}, mem_wdata_s[d], 16'h0);
    check_val({s, " busy"},   busy_s[d], 1'b0);
    check_val({s, " rdata0"}, m0_rdata_s[d], 16'h0);
    check_val({s, " rdata1"}, m1_rdata_s[d], 16'h0);
  endtask

  task automatic drive_cycle(input int d, input int c);
    txn_t t;
    for (int p = 0; p < 2; p++) begin
      if (drv_junk[c][p])
        drive_port(d, p, 1'b1, 1'($urandom), 8'($urandom), 16'($urandom));
      else if (drv_req[c][p]) begin
        t = drv_txn[c][p];
        drive_port(d, p, 1'b1, t.we, t.addr, t.data);
      end else
        drive_port(d, p, 1'b0, 1'($urandom), 8'($urandom), 16'($urandom));
    end
  endtask

  task automatic check_cycle(input int d, input int c);
    string s;
    s = $sformatf("i%0d c%0d", d, c);
    check_val({s, " gnt"},    {m1_gnt_s[d], m0_gnt_s[d]}, exp_gnt[c]);
    check_val({s, " rvalid"}, {m1_rvalid_s[d], m0_rvalid_s[d]}, exp_rv[c]);
    check_val({s, " mem_en"}, mem_en_s[d], exp_en[c]);
    check_val({s, " busy"},   busy_s[d], exp_busy[c]);
    check_val({s, " rdata0"}, m0_rdata_s[d], exp_rdv[c][0]);
    check_val({s, " rdata1"}, m1_rdata_s[d], exp_rdv[c][1]);
    if (exp_en[c]) begin
      check_val({s, " mem_we"},    mem_we_s[d], exp_we[c]);
      check_val({s, " mem_addr"},  mem_addr_s[d], exp_addr[c]);
      check_val({s, " mem_wdata"}, mem_wdata_s[d], exp_wdata[c]);
    end
  endtask

  // Serve the queued transactions in pq on instance d: derive the expected
  // timeline from the arbitration rules, then drive and compare every cycle.
  task automatic run_burst(input int d);
    int   cur, w, lat, end_c, nxt;
    int   idx [2];
    int   n [2];
    int   av [2];
    logic pend [2];
    logic [15:0] cur_rd [2];
    txn_t t;
    lat = lat_of(d);
    for (int c = 0; c < MAXC; c++) begin
      exp_gnt[c] = 2'b00; exp_rv[c] = 2'b00; exp_en[c] = 1'b0; exp_we[c] = 1'b0;
      exp_busy[c] = 1'b0; exp_addr[c] = 8'h0; exp_wdata[c] = 16'h0; rv_data[c] = 16'h0;
      for (int p = 0; p < 2; p++) begin
        drv_req[c][p] = 1'b0; drv_junk[c][p] = 1'b0; drv_txn[c][p] = '0;
      end
    end
    for (int p = 0; p < 2; p++) begin
      idx[p] = 0; n[p] = pq[p].size(); av[p] = start_av[p];
    end
    cur = 0;
    while (idx[0] < n[0] || idx[1] < n[1]) begin
      for (int p = 0; p < 2; p++) pend[p] = (idx[p] < n[p]) && (av[p] <= cur);
      if (!pend[0] && !pend[1]) begin
        cur++;
      end else begin
        if (pend[0] && pend[1]) w = rr_last[d] ? 0 : 1;
        else                    w = pend[1] ? 1 : 0;
        rr_last[d] = (w == 1);
        t = pq[w][idx[w]];
        for (int c = av[w]; c <= cur; c++) begin
          drv_req[c][w] = 1'b1; drv_txn[c][w] = t;
        end
        // Requester keeps req up through the grant cycle with garbage payload.
        drv_req[cur+1][w]  = 1'b1;
        drv_junk[cur+1][w] = 1'b1;
        exp_gnt[cur+1][w]  = 1'b1;
        exp_en[cur+1]      = 1'b1;
        exp_we[cur+1]      = t.we;
        exp_addr[cur+1]    = t.addr;
        exp_wdata[cur+1]   = t.data;
        if (t.we) begin
          ref_mem[d][t.addr] = t.data;
          exp_busy[cur+1] = 1'b1;
          nxt = cur + 2;
          $display("[TB] inst %0d port %0d write addr %02h data %04h gnt@%0d",
                   d, w, t.addr, t.data, cur + 1);
        end else begin
          for (int c = cur + 1; c <= cur + 2 + lat; c++) exp_busy[c] = 1'b1;
          exp_rv[cur+2+lat][w] = 1'b1;
          rv_data[cur+2+lat]   = ref_mem[d][t.addr];
          nxt = cur + 3 + lat;
          $display("[TB] inst %0d port %0d read  addr %02h data %04h gnt@%0d rvalid@%0d",
                   d, w, t.addr, ref_mem[d][t.addr], cur + 1, cur + 2 + lat);
        end
        idx[w]++;
        av[w] = cur + 2;
        cur = nxt;
      end
    end
    end_c = cur + 2;
    cur_rd[0] = exp_rd[d][0];
    cur_rd[1] = exp_rd[d][1];
    for (int c = 0; c <= end_c; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (exp_rv[c][p]) cur_rd[p] = rv_data[c];
        exp_rdv[c][p] = cur_rd[p];
      end
    end
    exp_rd[d][0] = cur_rd[0];
    exp_rd[d][1] = cur_rd[1];
    for (int c = 0; c <= end_c; c++) begin
      @(posedge clock); #1;
      drive_cycle(d, c);
      @(negedge clock);
      check_cycle(d, c);
    end
    pq[0].delete();
    pq[1].delete();
    start_av[0] = 0;
    start_av[1] = 0;
  endtask

  // Start a port-0 read, hit reset while the arbiter waits on memory.
  task automatic reset_in_wait(input int d);
    @(posedge clock); #1;
    drive_port(d, 0, 1'b1, 1'b0, 8'h00, 16'($urandom));
    @(negedge clock);
    check_val($sformatf("i%0d rst req busy", d), busy_s[d], 1'b0);
    @(posedge clock); #1;
    drive_port(d, 0, 1'b1, 1'($urandom), 8'($urandom), 16'($urandom));
    @(negedge clock);
    check_val($sformatf("i%0d rst gnt", d), {m1_gnt_s[d], m0_gnt_s[d]}, 2'b01);
    @(posedge clock); #1;
    drive_port(d, 0, 1'b0, 1'b0, 8'h00, 16'h0);
    reset = 1'b1;
    @(negedge clock);
    check_val($sformatf("i%0d rst wait busy", d), busy_s[d], 1'b1);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    for (int dd = 0; dd < NI; dd++) check_idle(dd, "after reset");
    @(posedge clock);
    @(negedge clock);
    check_idle(d, "after reset +1");
    $display("[TB] inst %0d read aborted by reset in WAIT", d);
  endtask

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    for (int d = 0; d < NI; d++)
      for (int a = 0; a < 256; a++) ref_mem[d][a] = init_word(d, a);
    model_reset();
    for (int d = 0; d < NI; d++)
      for (int p = 0; p < 2; p++) drive_port(d, p, 1'b0, 1'b0, 8'h00, 16'h0);
    start_av[0] = 0;
    start_av[1] = 0;
    repeat (3) @(posedge clock);
    #1;
    reset    = 1'b0;
    mem_init = 1'b0;
    @(negedge clock);
    for (int d = 0; d < NI; d++) check_idle(d, "reset");

    for (int d = 0; d < NI; d++) begin
      // Simultaneous reads straight after reset: port 0 goes first.
      pq[0].push_back(mk(1'b0, 8'h20, 16'h0));
      pq[1].push_back(mk(1'b0, 8'h21, 16'h0));
      run_burst(d);
      // Write then read back on port 0.
      pq[0].push_back(mk(1'b1, 8'h00, 16'd15));
      run_burst(d);
      pq[0].push_back(mk(1'b0, 8'h00, 16'h0));
      run_burst(d);
      // Both ports busy for six transactions: grants alternate.
      for (int k = 0; k < 3; k++) begin
        pq[0].push_back(mk(1'($urandom), rand_addr(), 16'($urandom)));
        pq[1].push_back(mk(1'($urandom), rand_addr(), 16'($urandom)));
      end
      run_burst(d);
      // Top address on port 1.
      pq[1].push_back(mk(1'b1, 8'hFF, 16'hBEEF));
      run_burst(d);
      pq[1].push_back(mk(1'b0, 8'hFF, 16'h0));
      run_burst(d);
      // Port 0 keeps req high across its grant while port 1 is waiting.
      pq[0].push_back(mk(1'b1, 8'h30, 16'hA5A5));
      pq[0].push_back(mk(1'b0, 8'h30, 16'h0));
      pq[1].push_back(mk(1'b0, 8'h31, 16'h0));
      run_burst(d);
      // Reset mid-read, then memory written before reset still reads back.
      reset_in_wait(d);
      pq[0].push_back(mk(1'b0, 8'h00, 16'h0));
      run_burst(d);
    end

    for (int r = 0; r < 10; r++) begin
      for (int p = 0; p < 2; p++) begin
        int n;
        n = $urandom_range(0, 4);
        start_av[p] = $urandom_range(0, 3);
        for (int k = 0; k < n; k++)
          pq[p].push_back(mk(1'($urandom), rand_addr(), 16'($urandom)));
      end
      run_burst(r % NI);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
